// File: rtl/pg_pkg.sv
// Shared types for the multi-channel adder/accumulator: operation modes and
// the channel-index width helper.
package pg_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SAT = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } pg_mode_e;

  // A single channel still needs a one-bit index so that in_ch exists.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pg_accum_core_if.sv
// Operation/result handshake bundle between the upstream source, the
// accumulator core and the downstream consumer.
interface pg_accum_core_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  import pg_pkg::*;

  localparam int CW = ch_width(CHANNELS);

  logic             in_valid;
  logic             in_ready;
  pg_mode_e         in_mode;
  logic [CW-1:0]    in_ch;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [CW-1:0]    out_ch;
  logic             ovf_sticky;

  modport master (
    output in_valid, in_mode, in_ch, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ch, ovf_sticky
  );

  modport slave (
    input  in_valid, in_mode, in_ch, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ch, ovf_sticky
  );

endinterface

// File: rtl/pg_acc_bank.sv
// Per-channel accumulator registers: one shared read/write index, cleared on
// reset. Indices beyond CHANNELS read as zero and never write.
module pg_acc_bank
  import pg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CW      = ch_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_hit,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic [WIDTH-1:0] acc_d [CHANNELS];

  always_comb begin
    acc_d   = acc_q;
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == CW'(i)) begin
        rd_data = acc_q[i];
        rd_hit  = 1'b1;
        if (wr_en) begin
          acc_d[i] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '{default: '0};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pg_accum_core.sv
// Multi-channel adder/accumulator with a single registered result stage,
// valid/ready handshake, saturating add and a sticky overflow flag.
module pg_accum_core
  import pg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CW      = ch_width(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst_n,
  pg_accum_core_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic [WIDTH-1:0] acc_rd;
  logic             acc_hit;
  logic             acc_wr_en;
  logic [WIDTH-1:0] acc_wr_data;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  pg_acc_bank #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (bus.in_ch),
    .rd_data (acc_rd),
    .rd_hit  (acc_hit),
    .wr_en   (acc_wr_en),
    .wr_data (acc_wr_data)
  );

  // Result datapath; accumulator writes are gated by accept so stalls and
  // idle cycles leave every channel untouched.
  always_comb begin
    full        = '0;
    res_sum     = '0;
    res_carry   = 1'b0;
    acc_wr_en   = 1'b0;
    acc_wr_data = '0;
    case (bus.in_mode)
      MODE_ADD: begin
        full      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        res_sum   = full[WIDTH-1:0];
        res_carry = full[WIDTH];
      end
      MODE_SAT: begin
        full      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        res_carry = full[WIDTH];
        res_sum   = full[WIDTH] ? '1 : full[WIDTH-1:0];
      end
      MODE_ACC: begin
        if (acc_hit) begin
          full        = {1'b0, acc_rd} + {1'b0, bus.in_a};
          res_sum     = full[WIDTH-1:0];
          res_carry   = full[WIDTH];
          acc_wr_en   = accept;
          acc_wr_data = full[WIDTH-1:0];
        end
      end
      MODE_CLR: begin
        if (acc_hit) begin
          res_sum     = acc_rd;
          acc_wr_en   = accept;
          acc_wr_data = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_carry_d  = out_carry_q;
    out_ch_d     = out_ch_q;
    ovf_sticky_d = ovf_sticky_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_sum_d    = res_sum;
      out_carry_d  = res_carry;
      out_ch_d     = bus.in_ch;
      ovf_sticky_d = ovf_sticky_q || res_carry;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_carry_q  <= 1'b0;
      out_ch_q     <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_carry_q  <= out_carry_d;
      out_ch_q     <= out_ch_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_pg_accum_core.sv
// Bench for pg_accum_core: a 4-channel and a 3-channel instance share one
// stimulus stream and are each checked every cycle against a plain model.
module tb_pg_accum_core;
  import pg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv;
  pg_mode_e   mode;
  logic [1:0] ch;
  logic [7:0] a;
  logic [7:0] b;
  logic       ordy;

  int  errors = 0;
  int  checks = 0;
  bit  checkEn = 1'b0;
  bit  acceptedLast = 1'b0;

  int  accM [2][4];
  bit  expValid [2];
  int  expSum [2];
  bit  expCarry [2];
  int  expCh [2];
  bit  expSticky [2];

  always #5 clk = ~clk;

  pg_accum_core_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  pg_accum_core_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  assign bus4.in_valid  = iv;
  assign bus4.in_mode   = mode;
  assign bus4.in_ch     = ch;
  assign bus4.in_a      = a;
  assign bus4.in_b      = b;
  assign bus4.out_ready = ordy;
  assign bus3.in_valid  = iv;
  assign bus3.in_mode   = mode;
  assign bus3.in_ch     = ch;
  assign bus3.in_a      = a;
  assign bus3.in_b      = b;
  assign bus3.out_ready = ordy;

  pg_accum_core #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  pg_accum_core #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // What one clock edge does to each model: results are computed from the
  // arithmetic rules directly, with integer sums and a modulo for wrapping.
  task automatic modelEdge();
    for (int m = 0; m < 2; m++) begin
      int  nch;
      int  tot;
      int  s;
      bit  c;
      bit  rdy;
      nch = (m == 0) ? 4 : 3;
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) accM[m][k] = 0;
        expValid[m]  = 0;
        expSum[m]    = 0;
        expCarry[m]  = 0;
        expCh[m]     = 0;
        expSticky[m] = 0;
        if (m == 0) acceptedLast = 1'b1;
      end else begin
        rdy = !expValid[m] || ordy;
        if (m == 0) acceptedLast = iv && rdy;
        if (iv && rdy) begin
          s = 0;
          c = 0;
          case (int'(mode))
            0: begin
              tot = int'(a) + int'(b);
              s = tot % 256;
              c = (tot > 255);
            end
            1: begin
              tot = int'(a) + int'(b);
              c = (tot > 255);
              s = c ? 255 : tot;
            end
            2: begin
              if (int'(ch) < nch) begin
                tot = accM[m][ch] + int'(a);
                accM[m][ch] = tot % 256;
                s = tot % 256;
                c = (tot > 255);
              end
            end
            default: begin
              if (int'(ch) < nch) begin
                s = accM[m][ch];
                accM[m][ch] = 0;
              end
            end
          endcase
          expValid[m] = 1;
          expSum[m]   = s;
          expCarry[m] = c;
          expCh[m]    = int'(ch);
          if (c) expSticky[m] = 1;
        end else if (ordy) begin
          expValid[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input int m, input string tag, input logic rdy,
                             input logic vld, input logic [7:0] sum,
                             input logic cry, input logic [1:0] och,
                             input logic stk);
    chk({tag, ".in_ready"},   int'(rdy), int'(!expValid[m] || ordy));
    chk({tag, ".out_valid"},  int'(vld), int'(expValid[m]));
    chk({tag, ".out_sum"},    int'(sum), expSum[m]);
    chk({tag, ".out_carry"},  int'(cry), int'(expCarry[m]));
    chk({tag, ".out_ch"},     int'(och), expCh[m]);
    chk({tag, ".ovf_sticky"}, int'(stk), int'(expSticky[m]));
  endtask

  // One clock: model follows the edge, then both DUTs are compared mid-cycle.
  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (checkEn) begin
      checkOutput(0, "dut4", bus4.in_ready, bus4.out_valid, bus4.out_sum,
                  bus4.out_carry, bus4.out_ch, bus4.ovf_sticky);
      checkOutput(1, "dut3", bus3.in_ready, bus3.out_valid, bus3.out_sum,
                  bus3.out_carry, bus3.out_ch, bus3.ovf_sticky);
    end
  endtask

  task automatic applyStimulus(input pg_mode_e md, input int c, input int aa, input int bb);
    iv   = 1'b1;
    mode = md;
    ch   = 2'(c);
    a    = 8'(aa);
    b    = 8'(bb);
    step();
  endtask

  initial begin
    iv   = 1'b1;
    mode = MODE_ADD;
    ch   = 2'd0;
    a    = 8'd0;
    b    = 8'd0;
    ordy = 1'b1;
    rst_n = 1'b0;
    step();
    checkEn = 1'b1;
    step();
    rst_n = 1'b1;
    iv = 1'b0;
    #1;
    chk("lit.reset_valid",  int'(bus4.out_valid), 0);
    chk("lit.reset_sticky", int'(bus4.ovf_sticky), 0);
    chk("lit.reset_ready",  int'(bus4.in_ready), 1);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(MODE_CLR, k, 0, 0);
      chk("lit.clr_after_reset", int'(bus4.out_sum), 0);
    end

    applyStimulus(MODE_ADD, 1, 200, 100);
    chk("lit.add_sum", int'(bus4.out_sum), 44);
    chk("lit.add_carry", int'(bus4.out_carry), 1);
    chk("lit.add_sticky", int'(bus4.ovf_sticky), 1);
    chk("lit.add_ch", int'(bus4.out_ch), 1);
    applyStimulus(MODE_SAT, 0, 200, 100);
    chk("lit.sat_sum", int'(bus4.out_sum), 255);
    chk("lit.sat_carry", int'(bus4.out_carry), 1);
    applyStimulus(MODE_SAT, 0, 3, 4);
    chk("lit.sat_small", int'(bus4.out_sum), 7);
    chk("lit.sat_small_carry", int'(bus4.out_carry), 0);

    applyStimulus(MODE_ACC, 2, 100, 77);
    chk("lit.acc1", int'(bus4.out_sum), 100);
    chk("lit.acc1_carry", int'(bus4.out_carry), 0);
    applyStimulus(MODE_ACC, 2, 100, 0);
    chk("lit.acc2", int'(bus4.out_sum), 200);
    applyStimulus(MODE_ACC, 2, 100, 0);
    chk("lit.acc3", int'(bus4.out_sum), 44);
    chk("lit.acc3_carry", int'(bus4.out_carry), 1);
    applyStimulus(MODE_CLR, 2, 0, 0);
    chk("lit.clr2", int'(bus4.out_sum), 44);
    chk("lit.clr2_carry", int'(bus4.out_carry), 0);
    applyStimulus(MODE_ACC, 2, 5, 0);
    chk("lit.acc_after_clr", int'(bus4.out_sum), 5);
    applyStimulus(MODE_CLR, 1, 0, 0);
    chk("lit.clr1_probe", int'(bus4.out_sum), 0);

    iv = 1'b0;
    step();
    ordy = 1'b0;
    applyStimulus(MODE_ADD, 0, 1, 1);
    chk("lit.bp_first", int'(bus4.out_sum), 2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(MODE_ADD, 0, 2, 2);
      chk("lit.bp_hold_sum", int'(bus4.out_sum), 2);
      chk("lit.bp_hold_ready", int'(bus4.in_ready), 0);
    end
    ordy = 1'b1;
    #1;
    chk("lit.bp_ready_comb", int'(bus4.in_ready), 1);
    step();
    chk("lit.bp_second", int'(bus4.out_sum), 4);
    chk("lit.bp_second_valid", int'(bus4.out_valid), 1);
    iv = 1'b0;
    step();
    chk("lit.bp_drained", int'(bus4.out_valid), 0);

    applyStimulus(MODE_ACC, 1, 50, 0);
    chk("lit.mid_acc", int'(bus4.out_sum), 50);
    rst_n = 1'b0;
    step();
    chk("lit.mid_reset_valid", int'(bus4.out_valid), 0);
    rst_n = 1'b1;
    applyStimulus(MODE_CLR, 1, 0, 0);
    chk("lit.mid_reset_clr1", int'(bus4.out_sum), 0);

    applyStimulus(MODE_ACC, 3, 9, 0);
    chk("lit.oor_sum", int'(bus3.out_sum), 0);
    chk("lit.oor_carry", int'(bus3.out_carry), 0);
    chk("lit.inrange_sum", int'(bus4.out_sum), 9);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(MODE_CLR, k, 0, 0);
      chk("lit.oor_clr", int'(bus3.out_sum), 0);
    end

    // Random traffic; an offer that was not taken is held until it is.
    iv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(iv && !acceptedLast)) begin
        iv   = ($urandom_range(0, 3) != 0);
        mode = pg_mode_e'(2'($urandom_range(0, 3)));
        ch   = 2'($urandom_range(0, 3));
        a    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(128, 255)) : 8'($urandom);
        b    = 8'($urandom);
      end
      ordy  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pg_accum_core.md
# pg_accum_core

Parametrised multi-channel adder/accumulator: next generation of the combinational pin adder, with registered output, valid/ready handshake, saturating mode and per-channel accumulators. Accepts one operation per cycle from an upstream source. Presents a registered result one cycle later. Sits between the pin-mapping top-level wrapper and the project I/O; the wrapper ties the handshake to pins and is not part of this block.

## Interface
Parameters:
- WIDTH, 8, operand/result/accumulator width (≥2)
- CHANNELS, 4, number of accumulator channels (≥1); CW = max(1, $clog2(CHANNELS))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_mode  in  2  0=ADD, 1=SAT, 2=ACC, 3=CLR
- in_ch  in  CW  channel for ACC/CLR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ADD/SAT only)
- out_valid  out  1  result held
- out_ready  in  1  downstream takes result
- out_sum  out  WIDTH  result
- out_carry  out  1  overflow/carry of this result
- out_ch  out  CW  in_ch echoed
- ovf_sticky  out  1  set on any result with out_carry=1, cleared only by reset

## Operation
- Accept = in_valid & in_ready. in_ready = !out_valid | out_ready (combinational from out_ready; no path from in_valid).
- On accept, output register loads {sum, carry, ch} and out_valid<=1; otherwise, if out_ready, out_valid<=0.
- ADD: full = a+b in WIDTH+1 bits; out_sum = full[WIDTH-1:0] (wraps mod 2^WIDTH), out_carry = full[WIDTH].
- SAT: as ADD, but on carry out_sum = all ones; out_carry = 1.
- ACC: acc[ch] <= acc[ch] + a (wrapping); out_sum = new acc value; out_carry = carry of that add. in_b ignored.
- CLR: out_sum = old acc[ch], out_carry = 0; acc[ch] <= 0 (read-and-clear).
- in_ch ≥ CHANNELS on ACC/CLR: accepted, no accumulator change, out_sum = 0, out_carry = 0. ADD/SAT ignore in_ch but echo it.
- Accumulators update only on accept. Back-to-back ACC on the same channel sees the previously accepted update; no hazard, no bubble.
- ovf_sticky sets in the same edge the carrying result is loaded.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_sum=0, out_carry=0, out_ch=0, ovf_sticky=0, all acc=0. in_ready=1 on the first cycle after reset.
- Reset mid-operation discards the held result and all accumulators. It overrides a simultaneous accept.
- Latency: result visible one cycle after the accept edge.
- Throughput: 1/cycle while out_ready=1.
- Stall: while out_valid & !out_ready, all outputs are stable and in_ready=0. Upstream must hold its operation.
- Simultaneous drain+accept (out_valid, out_ready, in_valid): old result leaves, new one loads in the same edge, and out_valid stays 1.

## Structure
- Package pg_pkg: mode constants/enum (MODE_ADD, MODE_SAT, MODE_ACC, MODE_CLR) and the 2-bit mode typedef.
- Sub-module pg_acc_bank: CHANNELS×WIDTH register array with one read port (in_ch), one write port (write enable, data) and synchronous clear-all on reset. Out-of-range index reads 0 and ignores writes.
- The top-level computes the arithmetic and owns the output register, handshake and sticky flag.

## Test plan
(WIDTH=8, CHANNELS=4)
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, ovf_sticky=0, in_ready=1 after release; CLR ch0..3 -> out_sum 0 each.
- ADD/SAT: ADD 200+100 -> out_sum 44, carry 1, ovf_sticky 1. SAT 200+100 -> 255, carry 1. SAT 3+4 -> 7, carry 0. Each result appears exactly 1 cycle after accept.
- ACC with CLR: ACC ch2 with a=100 three times back-to-back, out_ready=1 -> 100, 200, 44 (carry only on the third). Then CLR ch2 -> out_sum 44. ACC ch2 a=5 -> 5. Probing ch1 via CLR -> 0.
- Backpressure: out_ready=0 for 3 cycles while offering ADD 1+1 then ADD 2+2 -> result 2 held stable, in_ready=0. Raising out_ready drains 2 and accepts 2+2 in the same edge; 4 appears the next cycle.
- Out-of-range: CHANNELS=3 build, ACC in_ch=3 a=9 -> out_sum 0, carry 0; subsequent CLR ch0..2 -> all 0.
- Reset mid-run: after ACC ch1 a=50, assert rst_n=0 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle; CLR ch1 after release -> 0.
